// File: rtl/mult_control_unit.sv
// rtl/mult_control_unit.sv - sequencing controller for the 32-bit multiplier datapath
module mult_control_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       inputdata_ready,
  input  logic       mult_done,
  output logic       loaddata,
  output logic       load_operand,
  output logic [1:0] load_byte,
  output logic       mult_start,
  output logic       disp_half,
  output logic       result_valid,
  output logic       error,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_SHOW_HI = 3'd5;
  localparam logic [2:0] S_SHOW_LO = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic [2:0]    state;
  logic [CW-1:0] counter;
  logic          enter_sync1;
  logic          enter_sync2;
  logic          enter_prev;
  logic          enter_edge;

  // Two-flop synchronizer plus history flop: one pulse per press, however long it is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enter_sync1 <= 1'b0;
      enter_sync2 <= 1'b0;
      enter_prev  <= 1'b0;
    end else begin
      enter_sync1 <= enter;
      enter_sync2 <= enter_sync1;
      enter_prev  <= enter_sync2;
    end
  end

  assign enter_edge = enter_sync2 & ~enter_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      load_byte    <= 2'd3;
      load_operand <= 1'b0;
      counter      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enter_edge) begin
            state        <= S_LOAD_A;
            load_byte    <= 2'd3;
            load_operand <= 1'b0;
          end
        end
        S_LOAD_A: begin
          if (inputdata_ready) begin
            if (load_byte == 2'd0) begin
              state        <= S_LOAD_B;
              load_byte    <= 2'd3;
              load_operand <= 1'b1;
            end else begin
              load_byte <= load_byte - 2'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (inputdata_ready) begin
            if (load_byte == 2'd0) begin
              state <= S_START;
            end else begin
              load_byte <= load_byte - 2'd1;
            end
          end
        end
        S_START: begin
          counter <= CNT_LOAD;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the last counted cycle still counts as success
          if (mult_done) begin
            state <= S_SHOW_HI;
          end else if (counter == '0) begin
            state <= S_ERR;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        S_SHOW_HI: begin
          if (enter_edge) state <= S_SHOW_LO;
        end
        S_SHOW_LO: begin
          if (enter_edge) state <= S_IDLE;
        end
        S_ERR: begin
          if (enter_edge) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign loaddata     = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign mult_start   = (state == S_START);
  assign disp_half    = (state != S_SHOW_LO);
  assign result_valid = (state == S_SHOW_HI) || (state == S_SHOW_LO);
  assign error        = (state == S_ERR);
  assign state_dbg    = state;

endmodule

// File: tb/tb_mult_control_unit.sv
// tb/tb_mult_control_unit.sv - randomized self-checking bench for mult_control_unit
module tb_mult_control_unit;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       inputdata_ready = 1'b0;
  logic       mult_done = 1'b0;
  logic       loaddata;
  logic       load_operand;
  logic [1:0] load_byte;
  logic       mult_start;
  logic       disp_half;
  logic       result_valid;
  logic       error;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  mult_control_unit #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .enter           (enter),
    .inputdata_ready (inputdata_ready),
    .mult_done       (mult_done),
    .loaddata        (loaddata),
    .load_operand    (load_operand),
    .load_byte       (load_byte),
    .mult_start      (mult_start),
    .disp_half       (disp_half),
    .result_valid    (result_valid),
    .error           (error),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected Moore outputs for an abstract state number
  task automatic check_outputs(input string tag, input int st);
    check({tag, ".state"},        32'(state_dbg),    32'(st));
    check({tag, ".loaddata"},     32'(loaddata),     32'(st == 1 || st == 2));
    check({tag, ".mult_start"},   32'(mult_start),   32'(st == 3));
    check({tag, ".disp_half"},    32'(disp_half),    32'(st != 6));
    check({tag, ".result_valid"}, 32'(result_valid), 32'(st == 5 || st == 6));
    check({tag, ".error"},        32'(error),        32'(st == 7));
  endtask

  task automatic press(input int hold);
    enter = 1'b1;
    repeat (hold) tick();
    enter = 1'b0;
    repeat (3) tick();
  endtask

  // d: WAIT cycle (1-based) in which mult_done is raised; outside 1..TO means never
  task automatic run_round(input int d, input int reset_at);
    bit sim;
    check_outputs("idle", 0);
    inputdata_ready = 1'b1;
    tick();
    inputdata_ready = 1'b0;
    check_outputs("idle_rdy", 0);
    press($urandom_range(1, 6));
    check_outputs("to_load_a", 1);

    for (int n = 0; n < 8; n++) begin
      check_outputs(n < 4 ? "load_a" : "load_b", n < 4 ? 1 : 2);
      check("operand", 32'(load_operand), 32'(n / 4));
      check("byte", 32'(load_byte), 32'(3 - n % 4));
      if (n == reset_at) begin
        #2 reset = 1'b0;
        #1;
        check_outputs("rst", 0);
        check("rst.byte", 32'(load_byte), 32'd3);
        check("rst.operand", 32'(load_operand), 32'd0);
        tick();
        reset = 1'b1;
        repeat (4) begin
          inputdata_ready = 1'b1;
          tick();
          inputdata_ready = 1'b0;
          tick();
        end
        check_outputs("rst_quiet", 0);
        return;
      end
      if (n == 5) begin
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        check_outputs("done_in_load", 2);
        check("done_in_load.byte", 32'(load_byte), 32'd2);
      end
      repeat ($urandom_range(0, 2)) tick();
      sim = (n == 0) || (n < 7 && $urandom_range(0, 3) == 0);
      enter = sim;
      inputdata_ready = 1'b1;
      tick();
      inputdata_ready = 1'b0;
      enter = 1'b0;
      if (sim) repeat (3) tick();
    end

    check_outputs("start", 3);
    tick();
    for (int j = 1; j <= TO; j++) begin
      check_outputs("wait", 4);
      if (j == d) mult_done = 1'b1;
      tick();
      if (j == d) break;
    end

    if (d >= 1 && d <= TO) begin
      check_outputs("show_hi", 5);
      tick();
      mult_done = 1'b0;
      inputdata_ready = 1'b1;
      tick();
      inputdata_ready = 1'b0;
      check_outputs("show_hi_hold", 5);
      press($urandom_range(1, 6));
      check_outputs("show_lo", 6);
      press($urandom_range(1, 6));
      check_outputs("back_idle", 0);
    end else begin
      check_outputs("err", 7);
      press($urandom_range(1, 6));
      check_outputs("err_clear", 0);
    end
  endtask

  initial begin
    #1;
    check_outputs("reset_now", 0);
    repeat (2) tick();
    check_outputs("reset", 0);
    check("reset.byte", 32'(load_byte), 32'd3);
    check("reset.operand", 32'(load_operand), 32'd0);
    reset = 1'b1;
    tick();

    // Long hold: one transition, two edges after the first sampling edge
    enter = 1'b1;
    tick();
    check("hold.k", 32'(state_dbg), 32'd0);
    tick();
    check("hold.k1", 32'(state_dbg), 32'd0);
    tick();
    check("hold.k2", 32'(state_dbg), 32'd1);
    repeat (17) tick();
    check("hold.end", 32'(state_dbg), 32'd1);
    check("hold.byte", 32'(load_byte), 32'd3);
    enter = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();

    run_round(TO, -1);
    run_round(0, -1);
    run_round(1, -1);
    run_round(3, 5);
    run_round(2, -1);
    for (int r = 0; r < 6; r++) run_round($urandom_range(0, TO + 1), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
